// File: rtl/seg7_mux_receiver.sv
// Receiver/decoder for a two-digit multiplexed seven-segment bus; publishes {digit10, digit1}.
// Optional macro SEG7_RX_DP_EN adds per-digit decimal-point capture on seg_in[7].
module seg7_mux_receiver #(
    parameter int MIN_ON        = 2,
    parameter int STABLE_FRAMES = 3,
    parameter int TIMEOUT       = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seg_in,
    input  logic [1:0] com_in,
    input  logic       seg_active_high,
    input  logic       com_active_high,
    output logic [3:0] digit1,
    output logic [3:0] digit10,
    output logic       value_valid,
    output logic       value_strobe,
    output logic       seg_error,
    output logic       display_on,
    output logic [1:0] dp
);

    localparam int ON_W    = $clog2(MIN_ON + 1);
    localparam int MATCH_W = $clog2(STABLE_FRAMES + 1);
    localparam int IDLE_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {OFF, ACQUIRE, LOCKED} state_t;

    // Returns {legal, bcd}; an all-dark pattern is legal only where blanking is allowed.
    function automatic logic [4:0] decode(input logic [6:0] p, input logic blank_ok);
        case (p)
            7'h3F:        return {1'b1, 4'd0};
            7'h06:        return {1'b1, 4'd1};
            7'h5B:        return {1'b1, 4'd2};
            7'h4F:        return {1'b1, 4'd3};
            7'h66:        return {1'b1, 4'd4};
            7'h6D:        return {1'b1, 4'd5};
            7'h7D, 7'h7C: return {1'b1, 4'd6};
            7'h07, 7'h27: return {1'b1, 4'd7};
            7'h7F:        return {1'b1, 4'd8};
            7'h6F, 7'h67: return {1'b1, 4'd9};
            7'h00:        return {blank_ok, 4'd0};
            default:      return 5'd0;
        endcase
    endfunction

    logic [7:0] seg_p0, seg_p1;
    logic [1:0] com_p0, com_p1;

    // Stage p0/p1: two-flop synchroniser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            com_p0 <= 2'b00;
            com_p1 <= 2'b00;
        end else begin
            com_p0 <= com_in;
            com_p1 <= com_p0;
        end
    end

    always_ff @(posedge clk) begin
        seg_p0 <= seg_in;
        seg_p1 <= seg_p0;
    end

    logic [7:0] seg_n;
    logic [1:0] com_n;
    logic       overlap;

    assign seg_n   = seg_p1 ^ {8{~seg_active_high}};
    assign com_n   = com_p1 ^ {2{~com_active_high}};
    assign overlap = &com_n;

    logic [ON_W-1:0]    on_cnt    [2];
    logic [MATCH_W-1:0] match_cnt [2];
    logic [IDLE_W-1:0]  idle_cnt  [2];
    logic [3:0]         cand_val  [2];
    logic [4:0]         dec       [2];
    logic [1:0]         cand_valid, cap, same, stable, dark, bad;
`ifdef SEG7_RX_DP_EN
    logic [1:0]         cand_dp;
`endif

    // Per-channel capture, decode and stability tracking
    for (genvar i = 0; i < 2; i++) begin : g_ch
        logic sole;
        assign sole      = com_n[i] & ~overlap;
        assign cap[i]    = sole && (on_cnt[i] == ON_W'(MIN_ON - 1));
        assign dec[i]    = decode(seg_n[6:0], (i == 1));
        assign bad[i]    = cap[i] & ~dec[i][4];
        assign stable[i] = cand_valid[i] && (match_cnt[i] == MATCH_W'(STABLE_FRAMES));
        assign dark[i]   = (idle_cnt[i] == IDLE_W'(TIMEOUT));
`ifdef SEG7_RX_DP_EN
        assign same[i]   = cand_valid[i] && (cand_val[i] == dec[i][3:0]) && (cand_dp[i] == seg_n[7]);
`else
        assign same[i]   = cand_valid[i] && (cand_val[i] == dec[i][3:0]);
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                on_cnt[i]     <= '0;
                idle_cnt[i]   <= '0;
                match_cnt[i]  <= '0;
                cand_valid[i] <= 1'b0;
            end else begin
                if (!sole)
                    on_cnt[i] <= '0;
                else if (on_cnt[i] != ON_W'(MIN_ON))
                    on_cnt[i] <= on_cnt[i] + 1'b1;

                if (cap[i])
                    idle_cnt[i] <= '0;
                else if (!dark[i])
                    idle_cnt[i] <= idle_cnt[i] + 1'b1;

                if (cap[i]) begin
                    if (!dec[i][4]) begin
                        match_cnt[i]  <= '0;
                        cand_valid[i] <= 1'b0;
                    end else if (same[i]) begin
                        if (!stable[i])
                            match_cnt[i] <= match_cnt[i] + 1'b1;
                    end else begin
                        match_cnt[i]  <= MATCH_W'(1);
                        cand_valid[i] <= 1'b1;
                    end
                end else if (dark[i]) begin
                    match_cnt[i]  <= '0;
                    cand_valid[i] <= 1'b0;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (cap[i] && dec[i][4]) begin
                cand_val[i] <= dec[i][3:0];
`ifdef SEG7_RX_DP_EN
                cand_dp[i]  <= seg_n[7];
`endif
            end
        end
    end

    state_t     state;
    logic       ready, changed, both_dark;
    logic [3:0] new_d10;
    assign both_dark = &dark;
    assign ready     = stable[0] && (stable[1] || dark[1]);
    assign new_d10   = stable[1] ? cand_val[1] : 4'd0;

`ifdef SEG7_RX_DP_EN
    logic [1:0] new_dp, dp_q;
    assign new_dp  = {stable[1] & cand_dp[1], cand_dp[0]};
    assign changed = ({new_d10, cand_val[0], new_dp} != {digit10, digit1, dp_q});
    assign dp      = dp_q;
`else
    assign changed = ({new_d10, cand_val[0]} != {digit10, digit1});
    assign dp      = 2'b00;
`endif

    // Publish stage: FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= OFF;
            digit1       <= 4'd0;
            digit10      <= 4'd0;
            value_valid  <= 1'b0;
            value_strobe <= 1'b0;
            seg_error    <= 1'b0;
            display_on   <= 1'b0;
`ifdef SEG7_RX_DP_EN
            dp_q         <= 2'b00;
`endif
        end else begin
            value_strobe <= 1'b0;
            seg_error    <= |bad;
            if (state == OFF) begin
                if (|cap) begin
                    state      <= ACQUIRE;
                    display_on <= 1'b1;
                end
            end else if (both_dark) begin
                state       <= OFF;
                display_on  <= 1'b0;
                value_valid <= 1'b0;
            end else if (ready && (state == ACQUIRE || changed)) begin
                state        <= LOCKED;
                digit1       <= cand_val[0];
                digit10      <= new_d10;
                value_valid  <= 1'b1;
                value_strobe <= 1'b1;
`ifdef SEG7_RX_DP_EN
                dp_q         <= new_dp;
`endif
            end
        end
    end

endmodule

// File: tb/tb_seg7_mux_receiver.sv
// Directed self-checking bench for seg7_mux_receiver (default build, decimal points disabled).
module tb_seg7_mux_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seg_in = 8'h00;
    logic [1:0] com_in = 2'b00;
    logic       seg_pol = 1'b1;
    logic       com_pol = 1'b1;
    logic [3:0] digit1, digit10;
    logic       value_valid, value_strobe, seg_error, display_on;
    logic [1:0] dp;

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;
    int saw8_cnt = 0;

    seg7_mux_receiver dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .com_in(com_in),
        .seg_active_high(seg_pol), .com_active_high(com_pol),
        .digit1(digit1), .digit10(digit10), .value_valid(value_valid),
        .value_strobe(value_strobe), .seg_error(seg_error),
        .display_on(display_on), .dp(dp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (value_strobe) strobe_cnt++;
            if (seg_error) err_cnt++;
            if (digit1 == 4'd8) saw8_cnt++;
        end
    end

    // act is the logical (active-high) common mask, pat the logical segment pattern
    task automatic drive(input logic [1:0] act, input logic [7:0] pat);
        com_in = com_pol ? act : ~act;
        seg_in = seg_pol ? pat : ~pat;
    endtask

    task automatic run_frames(input logic [7:0] tens, input logic [7:0] ones,
                              input int n, input bit ones_only);
        for (int f = 0; f < n; f++) begin
            if (ones_only) drive(2'b00, 8'h00);
            else           drive(2'b10, tens);
            repeat (4) @(posedge clk);
            #1;
            drive(2'b01, ones);
            repeat (4) @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({digit10, digit1} !== 8'h00) begin
            fails++; $display("FAIL reset_digits got %h want 00", {digit10, digit1});
        end
        tests++;
        if ({value_valid, value_strobe, seg_error, display_on} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags got %b want 0000",
                              {value_valid, value_strobe, seg_error, display_on});
        end
        tests++;
        if (dp !== 2'b00) begin
            fails++; $display("FAIL reset_dp got %b want 00", dp);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int s0;
        s0 = strobe_cnt;
        run_frames(8'h06, 8'h4F, 6, 1'b0);
        @(negedge clk);
        tests++;
        if ({digit10, digit1} !== 8'h13) begin
            fails++; $display("FAIL basic_value got %h want 13", {digit10, digit1});
        end
        tests++;
        if (value_valid !== 1'b1) begin
            fails++; $display("FAIL basic_valid got %b want 1", value_valid);
        end
        tests++;
        if (display_on !== 1'b1) begin
            fails++; $display("FAIL basic_display_on got %b want 1", display_on);
        end
        tests++;
        if (strobe_cnt - s0 != 1) begin
            fails++; $display("FAIL basic_strobes got %0d want 1", strobe_cnt - s0);
        end
        tests++;
        if (dp !== 2'b00) begin
            fails++; $display("FAIL basic_dp got %b want 00", dp);
        end
    endtask

    task automatic test_polarity();
        seg_pol = 1'b0;
        com_pol = 1'b0;
        run_frames(8'h5B, 8'h3F, 6, 1'b0);
        @(negedge clk);
        tests++;
        if ({digit10, digit1} !== 8'h20) begin
            fails++; $display("FAIL polarity_value got %h want 20", {digit10, digit1});
        end
        tests++;
        if (value_valid !== 1'b1) begin
            fails++; $display("FAIL polarity_valid got %b want 1", value_valid);
        end
        seg_pol = 1'b1;
        com_pol = 1'b1;
    endtask

    task automatic test_blanking();
        run_frames(8'h00, 8'h7D, 14, 1'b1);
        @(negedge clk);
        tests++;
        if ({digit10, digit1} !== 8'h06) begin
            fails++; $display("FAIL blank_value got %h want 06", {digit10, digit1});
        end
        tests++;
        if (value_valid !== 1'b1) begin
            fails++; $display("FAIL blank_valid got %b want 1", value_valid);
        end
    endtask

    task automatic test_glitch_reject();
        int s0, e8;
        run_frames(8'h06, 8'h6D, 6, 1'b0);
        @(negedge clk);
        tests++;
        if ({digit10, digit1} !== 8'h15) begin
            fails++; $display("FAIL glitch_pre got %h want 15", {digit10, digit1});
        end
        s0 = strobe_cnt;
        e8 = saw8_cnt;
        run_frames(8'h06, 8'h7F, 1, 1'b0);
        run_frames(8'h06, 8'h07, 6, 1'b0);
        @(negedge clk);
        tests++;
        if (saw8_cnt != e8) begin
            fails++; $display("FAIL glitch_no8 got %0d cycles of 8 want 0", saw8_cnt - e8);
        end
        tests++;
        if (strobe_cnt - s0 != 1) begin
            fails++; $display("FAIL glitch_strobes got %0d want 1", strobe_cnt - s0);
        end
        tests++;
        if ({digit10, digit1} !== 8'h17) begin
            fails++; $display("FAIL glitch_value got %h want 17", {digit10, digit1});
        end
    endtask

    task automatic test_seg_error();
        int s0, e0;
        s0 = strobe_cnt;
        e0 = err_cnt;
        run_frames(8'h06, 8'h49, 2, 1'b0);
        @(negedge clk);
        tests++;
        if (err_cnt - e0 < 1) begin
            fails++; $display("FAIL segerr_pulse got %0d want >=1", err_cnt - e0);
        end
        tests++;
        if (strobe_cnt != s0) begin
            fails++; $display("FAIL segerr_strobes got %0d want 0", strobe_cnt - s0);
        end
        tests++;
        if ({digit10, digit1} !== 8'h17) begin
            fails++; $display("FAIL segerr_hold got %h want 17", {digit10, digit1});
        end
        tests++;
        if (value_valid !== 1'b1) begin
            fails++; $display("FAIL segerr_valid got %b want 1", value_valid);
        end
    endtask

    task automatic test_dark_and_reset();
        drive(2'b00, 8'h00);
        repeat (90) @(posedge clk);
        @(negedge clk);
        tests++;
        if (display_on !== 1'b0) begin
            fails++; $display("FAIL dark_display_on got %b want 0", display_on);
        end
        tests++;
        if (value_valid !== 1'b0) begin
            fails++; $display("FAIL dark_valid got %b want 0", value_valid);
        end
        tests++;
        if ({digit10, digit1} !== 8'h17) begin
            fails++; $display("FAIL dark_hold got %h want 17", {digit10, digit1});
        end
        run_frames(8'h06, 8'h07, 2, 1'b0);
        drive(2'b01, 8'h07);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if ({digit10, digit1, value_valid, value_strobe, seg_error, display_on, dp} !== 14'h0) begin
            fails++; $display("FAIL async_reset got %h want 0",
                              {digit10, digit1, value_valid, value_strobe, seg_error, display_on, dp});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_polarity();
        test_blanking();
        test_glitch_reject();
        test_seg_error();
        test_dark_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
